// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a W-bit universal shift register: issues load/shift steps
// spaced by STEP_GAP hold cycles. Define USR_SEQ_ROTATE_EN to add the cmd_rot input.
module usr_seq_ctrl #(
  parameter int W        = 4,
  parameter int CNT_W    = 3,
  parameter int STEP_GAP = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
`ifdef USR_SEQ_ROTATE_EN
  input  logic             cmd_rot,
`endif
  input  logic [W-1:0]     cmd_data,
  output logic [1:0]       usr_sel,
  output logic             usr_shift_l,
  output logic             usr_shift_r,
  output logic [W-1:0]     usr_din,
  input  logic [W-1:0]     usr_q,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STEP_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              fill_q, fill_d;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [W-1:0]      din_q, din_d;
  logic [1:0]        sel_q, sel_d;
  logic              shl_q, shl_d;
  logic              shr_q, shr_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fill_bit;

`ifdef USR_SEQ_ROTATE_EN
  logic rot_q, rot_d;
`else
  logic unused_usr_q;
  assign unused_usr_q = ^usr_q;
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fill_d  = fill_q;
    steps_d = steps_q;
    gap_d   = gap_q;
    din_d   = din_q;
`ifdef USR_SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = op_t'(cmd_op);
          fill_d = cmd_fill;
          din_d  = cmd_data;
`ifdef USR_SEQ_ROTATE_EN
          rot_d  = cmd_rot;
`endif
          unique case (op_t'(cmd_op))
            OP_NOP:  steps_d = '0;
            OP_LOAD: steps_d = CNT_W'(1);
            default: steps_d = cmd_cnt;
          endcase
          state_d = (steps_d == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        steps_d = steps_q - CNT_W'(1);
        gap_d   = GAP_LAST;
        state_d = WAIT;
      end
      WAIT: begin
        if (gap_q == '0) begin
          state_d = (steps_q != '0) ? ISSUE : DONE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they arrive registered in that state.
`ifdef USR_SEQ_ROTATE_EN
    if (rot_d) fill_bit = (op_d == OP_SHL) ? usr_q[W-1] : usr_q[0];
    else       fill_bit = fill_d;
`else
    fill_bit = fill_d;
`endif
    sel_d = 2'b00;
    shl_d = 1'b0;
    shr_d = 1'b0;
    if (state_d == ISSUE) begin
      sel_d = op_d;
      shl_d = (op_d == OP_SHL) && fill_bit;
      shr_d = (op_d == OP_SHR) && fill_bit;
    end
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      fill_q  <= 1'b0;
      steps_q <= '0;
      gap_q   <= '0;
      din_q   <= '0;
      sel_q   <= 2'b00;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef USR_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      steps_q <= steps_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef USR_SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign cmd_ready   = ready_q;
  assign usr_sel     = sel_q;
  assign usr_shift_l = shl_q;
  assign usr_shift_r = shr_q;
  assign usr_din     = din_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Scoreboard bench for usr_seq_ctrl driving a 3-stage-latency USR model.
// The driver queues expected results; a negedge monitor checks issues and done.
module tb_usr_seq_ctrl;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_cnt = 3'd0;
  logic       cmd_fill = 1'b0;
  logic       cmd_rot = 1'b0;
  logic [3:0] cmd_data = 4'h0;
  logic [1:0] usr_sel;
  logic       usr_shift_l, usr_shift_r;
  logic [3:0] usr_din;
  logic [3:0] usr_q;
  logic       busy, done;

  always #5 clk = ~clk;

  usr_seq_ctrl #(.W(4), .CNT_W(3), .STEP_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
`ifdef USR_SEQ_ROTATE_EN
    .cmd_rot(cmd_rot),
`endif
    .cmd_data(cmd_data),
    .usr_sel(usr_sel), .usr_shift_l(usr_shift_l), .usr_shift_r(usr_shift_r),
    .usr_din(usr_din), .usr_q(usr_q),
    .busy(busy), .done(done)
  );

`ifndef USR_SEQ_ROTATE_EN
  wire unused_rot = cmd_rot;
`endif

  // USR model: control is delayed two stages, applied on the third edge.
  logic [1:0] p1_sel, p2_sel;
  logic       p1_l, p2_l, p1_r, p2_r;
  logic [3:0] p1_d, p2_d;

  always @(posedge clk) begin
    if (rst) begin
      p1_sel <= 2'b00; p2_sel <= 2'b00;
      p1_l <= 1'b0; p2_l <= 1'b0; p1_r <= 1'b0; p2_r <= 1'b0;
      p1_d <= 4'h0; p2_d <= 4'h0;
      usr_q <= 4'h0;
    end else begin
      p1_sel <= usr_sel; p1_l <= usr_shift_l; p1_r <= usr_shift_r; p1_d <= usr_din;
      p2_sel <= p1_sel;  p2_l <= p1_l;        p2_r <= p1_r;        p2_d <= p1_d;
      case (p2_sel)
        2'b01:   usr_q <= {usr_q[2:0], p2_l};
        2'b10:   usr_q <= {p2_r, usr_q[3:1]};
        2'b11:   usr_q <= p2_d;
        default: usr_q <= usr_q;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] sel;
    int         n;
    logic       fl;
    logic       fr;
    logic [3:0] din;
    logic [3:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int cur_t = 0;
  int issues = 0;
  bit active = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (usr_sel != 2'b00) begin
        if (!active || exp_q.size() == 0) begin
          check("unexpected_issue", 32'(usr_sel), 32'd0);
        end else begin
          check("issue_sel",    32'(usr_sel),     32'(exp_q[0].sel));
          check("issue_cycle",  32'(cyc),         32'(cur_t + issues * (GAP + 1)));
          check("issue_fill_l", 32'(usr_shift_l), 32'(exp_q[0].fl));
          check("issue_fill_r", 32'(usr_shift_r), 32'(exp_q[0].fr));
          check("issue_din",    32'(usr_din),     32'(exp_q[0].din));
          issues++;
        end
      end else begin
        check("idle_fill", 32'({usr_shift_l, usr_shift_r}), 32'd0);
      end
      if (done) begin
        if (!active || exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          check("done_cycle", 32'(cyc),     32'(cur_t + exp_q[0].n * (GAP + 1)));
          check("done_steps", 32'(issues),  32'(exp_q[0].n));
          check("done_q",     32'(usr_q),   32'(exp_q[0].q));
          check("done_din",   32'(usr_din), 32'(exp_q[0].din));
          check("done_busy",  32'(busy),    32'd1);
          void'(exp_q.pop_front());
          active = 1'b0;
        end
      end
      if (rst) begin
        exp_q.delete();
        active = 1'b0;
      end else if (cmd_valid && cmd_ready) begin
        active = 1'b1;
        cur_t  = cyc + 1;
        issues = 0;
      end
    end
  end

  // efill is the hand-computed fill bit expected at each ISSUE of a shift.
  task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic fill,
                      input logic rot, input logic [3:0] data, input logic efill,
                      input logic [3:0] qexp);
    exp_t e;
    int   waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    e.sel = op;
    e.n   = (op == 2'b11) ? 1 : (op == 2'b00) ? 0 : int'(cnt);
    e.fl  = (op == 2'b01) ? efill : 1'b0;
    e.fr  = (op == 2'b10) ? efill : 1'b0;
    e.din = data;
    e.q   = qexp;
    exp_q.push_back(e);
    cmd_op = op; cmd_cnt = cnt; cmd_fill = fill; cmd_rot = rot; cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready),   32'd1);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_sel"},   32'(usr_sel),     32'd0);
    check({tag, "_fills"}, 32'({usr_shift_l, usr_shift_r}), 32'd0);
    check({tag, "_din"},   32'(usr_din),     32'd0);
    check({tag, "_usr_q"}, 32'(usr_q),       32'd0);
  endtask

  initial begin
    int waited;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    //   op     cnt   fill  rot   data   efill qexp
    send(2'b11, 3'd0, 1'b0, 1'b0, 4'hA, 1'b0, 4'hA);   // load 1010
    send(2'b01, 3'd2, 1'b1, 1'b0, 4'h0, 1'b1, 4'hB);   // shl 2 fill 1 -> 1011
    send(2'b11, 3'd0, 1'b0, 1'b0, 4'hA, 1'b0, 4'hA);   // reload 1010
    send(2'b10, 3'd0, 1'b1, 1'b0, 4'h5, 1'b1, 4'hA);   // shr cnt 0: immediate done
    send(2'b00, 3'd5, 1'b1, 1'b0, 4'hF, 1'b0, 4'hA);   // nop
    send(2'b10, 3'd7, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);   // shr 7 > W, fill 0 -> 0000
    send(2'b01, 3'd5, 1'b1, 1'b0, 4'h0, 1'b1, 4'hF);   // shl 5 > W, fill 1 -> 1111
    send(2'b11, 3'd0, 1'b0, 1'b0, 4'h3, 1'b0, 4'h3);   // load 0011
    send(2'b10, 3'd2, 1'b1, 1'b0, 4'h0, 1'b1, 4'hC);   // shr 2 fill 1 -> 1100

    // Abort a 3-step shr during its first WAIT.
    send(2'b10, 3'd3, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("mid_reset");

    send(2'b11, 3'd0, 1'b0, 1'b0, 4'h6, 1'b0, 4'h6);   // load 0110 after abort

`ifdef USR_SEQ_ROTATE_EN
    send(2'b11, 3'd0, 1'b0, 1'b0, 4'h9, 1'b0, 4'h9);   // load 1001
    send(2'b10, 3'd1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hC);   // rotate right -> 1100
    send(2'b01, 3'd1, 1'b0, 1'b1, 4'h0, 1'b1, 4'h9);   // rotate left  -> 1001
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("final_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
